// File: rtl/ram_arbiter_if.sv
// Request/response bundle between the core (fetch + LSU), the RAM arbiter and the SoC RAM.
// The arbiter connects through the slave modport; the core/RAM environment uses master.
interface ram_arbiter_if #(
    parameter int ADDR_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [63:0]       if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [63:0]       d_wdata;
    logic              d_ack;
    logic [63:0]       d_rdata;
    logic              d_err;

    logic              ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [63:0]       ram_write;
    logic [63:0]       ram_read;
    logic              ram_exc;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, ram_read, ram_exc,
        output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err, ram_rw, ram_addr, ram_write
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, ram_read, ram_exc,
        input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err, ram_rw, ram_addr, ram_write
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares the single-port 64-bit RAM between instruction fetch and load/store, with lane
// extraction and read-modify-write. Define RAM_ARB_RR_EN for strict round-robin arbitration.
module ram_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 64
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_RD   = 3'd1,
        D_RD   = 3'd2,
        RMW_RD = 3'd3,
        D_WR   = 3'd4,
        RESP   = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(7));

    state_t            state_r;
    logic              ram_rw_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [63:0]       ram_write_r;
    logic              if_ack_r;
    logic [63:0]       if_rdata_r;
    logic              if_err_r;
    logic              d_ack_r;
    logic [63:0]       d_rdata_r;
    logic              d_err_r;
    logic [1:0]        size_r;
    logic [2:0]        off_r;
    logic [63:0]       wdata_r;
    logic              grant_d_s;
    logic              grant_i_s;

`ifdef RAM_ARB_RR_EN
    logic              prio_i_r;
`else
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0]  starve_cnt_r;
`endif

    function automatic logic [63:0] size_mask_f(input logic [1:0] sz);
        logic [63:0] m;
        case (sz)
            2'd0:    m = 64'h0000_0000_0000_00ff;
            2'd1:    m = 64'h0000_0000_0000_ffff;
            2'd2:    m = 64'h0000_0000_ffff_ffff;
            default: m = 64'hffff_ffff_ffff_ffff;
        endcase
        return m;
    endfunction

    function automatic logic misaligned_f(input logic [2:0] off, input logic [1:0] sz);
        logic bad;
        case (sz)
            2'd0:    bad = 1'b0;
            2'd1:    bad = off[0];
            2'd2:    bad = (off[1:0] != 2'd0);
            default: bad = (off != 3'd0);
        endcase
        return bad;
    endfunction

    // Byte lanes offset .. offset+2^size-1 of the old cell take the low bytes of the store data.
    function automatic logic [63:0] merge_f(input logic [63:0] old_cell, input logic [63:0] wd,
                                            input logic [2:0] off, input logic [1:0] sz);
        logic [63:0] lane_m;
        lane_m = size_mask_f(sz) << {off, 3'b000};
        return (old_cell & ~lane_m) | ((wd << {off, 3'b000}) & lane_m);
    endfunction

    // Grant decision for the current IDLE cycle.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
`ifdef RAM_ARB_RR_EN
        if (bus.d_req && bus.if_req) begin
            grant_d_s = ~prio_i_r;
            grant_i_s = prio_i_r;
        end else begin
            grant_d_s = bus.d_req;
            grant_i_s = bus.if_req;
        end
`else
        if (bus.d_req && !(bus.if_req && (starve_cnt_r == CNT_W'(STARVE_MAX)))) begin
            grant_d_s = 1'b1;
        end else begin
            grant_i_s = bus.if_req;
        end
`endif
    end

    // Transaction sequencer with registered RAM-side and requester-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            ram_rw_r     <= 1'b0;
            ram_addr_r   <= '0;
            ram_write_r  <= 64'd0;
            if_ack_r     <= 1'b0;
            if_rdata_r   <= 64'd0;
            if_err_r     <= 1'b0;
            d_ack_r      <= 1'b0;
            d_rdata_r    <= 64'd0;
            d_err_r      <= 1'b0;
            size_r       <= 2'd0;
            off_r        <= 3'd0;
            wdata_r      <= 64'd0;
`ifdef RAM_ARB_RR_EN
            prio_i_r     <= 1'b0;
`else
            starve_cnt_r <= '0;
`endif
        end else begin
            if_ack_r <= 1'b0;
            d_ack_r  <= 1'b0;
            ram_rw_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        ram_addr_r <= bus.d_addr & ALIGN_MASK;
                        size_r     <= bus.d_size;
                        off_r      <= bus.d_addr[2:0];
                        wdata_r    <= bus.d_wdata;
                        if (misaligned_f(bus.d_addr[2:0], bus.d_size)) begin
                            d_err_r <= 1'b1;
                            d_ack_r <= 1'b1;
                            state_r <= RESP;
                        end else if (!bus.d_we) begin
                            state_r <= D_RD;
                        end else if (bus.d_size == 2'd3) begin
                            ram_write_r <= bus.d_wdata;
                            ram_rw_r    <= 1'b1;
                            state_r     <= D_WR;
                        end else begin
                            state_r <= RMW_RD;
                        end
                    end else if (grant_i_s) begin
                        ram_addr_r <= bus.if_addr & ALIGN_MASK;
                        state_r    <= I_RD;
                    end else begin
                        state_r <= IDLE;
                    end
`ifdef RAM_ARB_RR_EN
                    // The loser of a contested grant wins the next contested one.
                    if (bus.d_req && bus.if_req) begin
                        prio_i_r <= ~prio_i_r;
                    end else begin
                        prio_i_r <= prio_i_r;
                    end
`else
                    if (!bus.if_req || grant_i_s) begin
                        starve_cnt_r <= '0;
                    end else if (grant_d_s) begin
                        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
                    end else begin
                        starve_cnt_r <= starve_cnt_r;
                    end
`endif
                end
                I_RD: begin
                    if_rdata_r <= bus.ram_read;
                    if_err_r   <= bus.ram_exc;
                    if_ack_r   <= 1'b1;
                    state_r    <= RESP;
                end
                D_RD: begin
                    d_rdata_r <= (bus.ram_read >> {off_r, 3'b000}) & size_mask_f(size_r);
                    d_err_r   <= bus.ram_exc;
                    d_ack_r   <= 1'b1;
                    state_r   <= RESP;
                end
                RMW_RD: begin
                    ram_write_r <= merge_f(bus.ram_read, wdata_r, off_r, size_r);
                    if (bus.ram_exc) begin
                        d_err_r <= 1'b1;
                        d_ack_r <= 1'b1;
                        state_r <= RESP;
                    end else begin
                        ram_rw_r <= 1'b1;
                        state_r  <= D_WR;
                    end
                end
                D_WR: begin
                    d_err_r <= bus.ram_exc;
                    d_ack_r <= 1'b1;
                    state_r <= RESP;
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_rw    = ram_rw_r;
    assign bus.ram_addr  = ram_addr_r;
    assign bus.ram_write = ram_write_r;
    assign bus.if_ack    = if_ack_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.if_err    = if_err_r;
    assign bus.d_ack     = d_ack_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.d_err     = d_err_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: behavioural 16-cell RAM (cells above 0x80 raise ram_exc),
// expected responses queued at request time and checked when an ack appears.
module tb_ram_arbiter;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    typedef struct {
        bit          is_d;
        logic [63:0] data;
        logic        err;
        bit          chk_data;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] mem[16];
    logic        pre_we;
    logic [3:0]  pre_idx;
    logic [63:0] pre_data;
    int          wr_count;

    ram_arbiter_if #(.ADDR_W(64)) bus ();

    ram_arbiter #(.STARVE_MAX(2), .ADDR_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.ram_exc  = (bus.ram_addr >= 64'h80);
    assign bus.ram_read = bus.ram_exc ? 64'd0 : mem[bus.ram_addr[6:3]];

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (bus.ram_rw && !bus.ram_exc) begin
            mem[bus.ram_addr[6:3]] <= bus.ram_write;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Response monitor: every ack consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && (bus.d_ack || bus.if_ack)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_ack", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_port", {63'd0, bus.d_ack}, {63'd0, e.is_d});
                if (bus.d_ack) begin
                    check("sb_d_err", {63'd0, bus.d_err}, {63'd0, e.err});
                    if (e.chk_data) check("sb_d_rdata", bus.d_rdata, e.data);
                end else begin
                    check("sb_if_err", {63'd0, bus.if_err}, {63'd0, e.err});
                    if (e.chk_data) check("sb_if_rdata", bus.if_rdata, e.data);
                end
            end
        end
    end

    task automatic preload(input logic [3:0] idx, input logic [63:0] data);
        @(negedge clk);
        pre_idx  = idx;
        pre_data = data;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // One request; exp_rw_at < 0 means ram_rw must never rise.
    task automatic run_txn(input bit is_d, input logic we, input logic [1:0] sz,
                           input logic [63:0] addr, input logic [63:0] wd, input int exp_lat,
                           input int exp_rw_at, input logic exp_err, input logic [63:0] exp_data,
                           input bit chk_data);
        exp_t e;
        int   cyc;
        int   rw_n;
        int   rw_at;
        bit   got;
        e.is_d = is_d; e.data = exp_data; e.err = exp_err; e.chk_data = chk_data;
        sb_q.push_back(e);
        @(negedge clk);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_size = sz; bus.d_addr = addr; bus.d_wdata = wd;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        cyc = 0; rw_n = 0; rw_at = -1; got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.ram_rw) begin
                rw_n++;
                rw_at = cyc;
            end
            got = is_d ? bus.d_ack : bus.if_ack;
        end
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
        check(is_d ? "d_ack_seen" : "if_ack_seen", {63'd0, got}, 64'd1);
        check(is_d ? "d_latency" : "if_latency", 64'(cyc), 64'(exp_lat));
        check("ram_rw_cycles", 64'(rw_n), (exp_rw_at < 0) ? 64'd0 : 64'd1);
        if (exp_rw_at >= 0) check("ram_rw_cycle", 64'(rw_at), 64'(exp_rw_at));
        @(negedge clk);
        check("ack_pulse", {63'd0, bus.d_ack | bus.if_ack}, 64'd0);
    endtask

    initial begin
        int w0;
        int acks;
        int cyc;
        bit [5:0] order_d;
        n_total = 0; n_bad = 0; wr_count = 0;
        pre_we = 1'b0; pre_idx = 4'd0; pre_data = 64'd0;
        bus.if_req = 1'b0; bus.if_addr = 64'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'd0; bus.d_addr = 64'd0; bus.d_wdata = 64'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ram_rw", {63'd0, bus.ram_rw}, 64'd0);
        check("rst_ram_addr", bus.ram_addr, 64'd0);
        check("rst_ram_write", bus.ram_write, 64'd0);
        check("rst_acks", {62'd0, bus.if_ack, bus.d_ack}, 64'd0);
        check("rst_errs", {62'd0, bus.if_err, bus.d_err}, 64'd0);
        check("rst_if_rdata", bus.if_rdata, 64'd0);
        check("rst_d_rdata", bus.d_rdata, 64'd0);
        rst = 1'b0;

        preload(4'd0, 64'h0fc1059700100513);
        preload(4'd2, 64'h0000007304000893);
        preload(4'd4, 64'h1122334455667788);

        run_txn(1'b0, 1'b0, 2'd0, 64'h0, 64'd0, 2, -1, 1'b0, 64'h0fc1059700100513, 1'b1);
        run_txn(1'b1, 1'b0, 2'd0, 64'h1, 64'd0, 2, -1, 1'b0, 64'h05, 1'b1);
        run_txn(1'b1, 1'b0, 2'd2, 64'h4, 64'd0, 2, -1, 1'b0, 64'h0fc10597, 1'b1);
        check("if_rdata_hold", bus.if_rdata, 64'h0fc1059700100513);
        run_txn(1'b1, 1'b1, 2'd1, 64'h12, 64'hBEEF, 3, 2, 1'b0, 64'd0, 1'b0);
        run_txn(1'b1, 1'b0, 2'd3, 64'h10, 64'd0, 2, -1, 1'b0, 64'h00000073BEEF0893, 1'b1);
        run_txn(1'b1, 1'b0, 2'd2, 64'h6, 64'd0, 1, -1, 1'b1, 64'd0, 1'b0);
        run_txn(1'b1, 1'b1, 2'd3, 64'h18, 64'hCAFE_F00D_1234_5678, 2, 1, 1'b0, 64'd0, 1'b0);
        run_txn(1'b1, 1'b0, 2'd1, 64'h1E, 64'd0, 2, -1, 1'b0, 64'hCAFE, 1'b1);
        w0 = wr_count;
        run_txn(1'b1, 1'b1, 2'd0, 64'h2000, 64'h5A, 2, -1, 1'b1, 64'd0, 1'b0);
        check("exc_no_write", 64'(wr_count), 64'(w0));
        run_txn(1'b0, 1'b0, 2'd0, 64'h100, 64'd0, 2, -1, 1'b1, 64'd0, 1'b0);
        check("d_err_hold", {63'd0, bus.d_err}, 64'd1);

        // Both ports requesting continuously.
`ifdef RAM_ARB_RR_EN
        order_d = 6'b010101;
`else
        order_d = 6'b011011;
`endif
        for (int k = 0; k < 6; k++) begin
            exp_t e;
            e.is_d = order_d[k];
            e.data = order_d[k] ? 64'h00000073BEEF0893 : 64'h0fc1059700100513;
            e.err = 1'b0; e.chk_data = 1'b1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd3; bus.d_addr = 64'h10;
        bus.if_req = 1'b1; bus.if_addr = 64'h0;
        acks = 0; cyc = 0;
        while (acks < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.d_ack || bus.if_ack) acks++;
        end
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        check("contend_acks", 64'(acks), 64'd6);

        // Reset while a partial store sits in RMW_RD.
        w0 = wr_count;
        @(negedge clk);
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'd0; bus.d_addr = 64'h21; bus.d_wdata = 64'hAA;
        @(negedge clk);
        rst = 1'b1;
        bus.d_req = 1'b0;
        #1;
        check("rmw_rst_rw", {63'd0, bus.ram_rw}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rmw_rst_quiet", {62'd0, bus.ram_rw, bus.d_ack}, 64'd0);
        end
        rst = 1'b0;
        check("rmw_rst_no_write", 64'(wr_count), 64'(w0));
        check("rmw_rst_cell", mem[4], 64'h1122334455667788);
        run_txn(1'b0, 1'b0, 2'd0, 64'h20, 64'd0, 2, -1, 1'b0, 64'h1122334455667788, 1'b1);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sequences and shares the single-port 64-bit SoC RAM between the instruction-fetch port and the load/store data port of the core.
- Performs naturally aligned byte/half/word/double accesses on the 8-byte RAM cell: lane extraction on loads, read-modify-write on partial stores.
- Passes the RAM out-of-range exception back to the requester.
- Sits between the core front-end/LSU and the RAM.

Parameters:
- STARVE_MAX, 4: maximum consecutive data grants while a fetch is pending.
- ADDR_W, 64: address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch byte address; low 3 bits ignored.
- if_ack  out  1  one-cycle completion pulse.
- if_rdata  out  64  fetched 64-bit cell.
- if_err  out  1  valid with if_ack; RAM exception.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store.
- d_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  64  store data, right-aligned.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  64  load data, right-aligned, zero-extended.
- d_err  out  1  valid with d_ack; misaligned access or RAM exception.
- ram_rw  out  1  1 = write this cycle.
- ram_addr  out  ADDR_W  byte address, low 3 bits zero.
- ram_write  out  64  write cell.
- ram_read  in  64  combinational read cell.
- ram_exc  in  1  combinational out-of-range flag.

Behaviour:
- Reset: async; FSM to IDLE.
  - ram_rw = 0 immediately.
  - All acks, errs, rdata, ram_addr, ram_write, starvation counter and latched request fields are 0.
  - Reset mid-transaction abandons it with no ack. A pending RMW never writes.
- FSM states: IDLE, I_RD, D_RD, RMW_RD, D_WR, RESP.
- ram_rw = 1 only in D_WR.
- IDLE:
  - Sample requests and arbitrate.
  - Latch address (aligned), size, offset (addr[2:0]) and wdata.
  - Next state:
    - Fetch: I_RD.
    - Load: D_RD.
    - Double store: D_WR, with ram_write = d_wdata.
    - Partial store: RMW_RD.
    - Misaligned data access (addr[2:0] not a multiple of 2^size): RESP with d_err = 1, no RAM access.
- I_RD: capture ram_read into if_rdata and ram_exc into if_err; go to RESP.
- D_RD:
  - d_rdata = (ram_read >> 8*offset) masked to size bytes, zero-extended.
  - d_err = ram_exc; go to RESP.
- RMW_RD:
  - Latch ram_read into the merge buffer.
  - If ram_exc: d_err = 1, go to RESP.
  - Otherwise: replace bytes offset .. offset+2^size-1 with the low bytes of d_wdata, go to D_WR.
- D_WR: ram_rw = 1, ram_write = merge buffer; d_err = ram_exc; go to RESP.
- RESP:
  - The granted port's ack is high for exactly this cycle; err/rdata are valid and held until the next ack of that port.
  - Requests are not sampled in RESP; the requester drops or changes req at the following edge.
  - Next state: IDLE.
- Latency, counting the IDLE grant cycle as 0:
  - Fetch, load and double store: ack in cycle 2.
  - Partial store: ack in cycle 3.
  - Misaligned access: ack in cycle 1.
- Arbitration (default):
  - Data has priority.
  - The starvation counter increments on each data grant while if_req = 1.
  - When the counter equals STARVE_MAX and if_req = 1, the fetch is granted.
  - The counter clears on a fetch grant or whenever if_req = 0 in IDLE.
  - Single requester: always granted.
- Only the granted port's outputs change; the other port's rdata and err hold.
- Throughput: at most one transaction outstanding; no pipelining.

Optional Feature:
- Macro: RAM_ARB_RR_EN.
- Defined: strict round-robin arbitration.
  - A last-grant flag alternates when both ports request; the loser always wins the next contested arbitration.
  - STARVE_MAX and the counter are unused.
- Undefined: data-priority arbitration with the starvation counter, as above.

Test Plan:
- Preload cell 0 = 0x0fc1059700100513; if_req with addr 0x0 → if_ack in cycle 2, if_rdata = 0x0fc1059700100513, if_err = 0.
- Load byte at 0x1 and load word at 0x4 → d_rdata = 0x05, then 0x0fc10597, each acked in cycle 2.
- Cell 2 = 0x0000007304000893; store half 0xBEEF at 0x12 → ram_rw high for exactly one cycle (cycle 2), d_ack in cycle 3; a subsequent double load from 0x10 returns 0x00000073BEEF0893.
- Word load at 0x6 → d_ack in cycle 1 with d_err = 1; ram_rw never asserted.
- STARVE_MAX = 2, both requests held continuously → grant order D, D, I, D, D, I. With RAM_ARB_RR_EN: D, I, D, I.
- Store byte to 0x2000 with ram_exc = 1 → d_err = 1 after RMW_RD, no write. Separately, assert rst during RMW_RD → ram_rw stays 0, no ack, cell unchanged, FSM in IDLE.
